// File: rtl/ifft_pkg.sv
// Shared definitions for the IFFT frame feeder.
//   FFT_DATA_W    : width of the real and imaginary sample parts
//   FFT_FRAME_LEN : samples per IFFT frame (power of two)
//   FFT_ADDR_W    : log2(FFT_FRAME_LEN)
//   rd_state_t    : read-side FSM state encoding
package ifft_pkg;

   localparam int FFT_DATA_W    = 8;
   localparam int FFT_FRAME_LEN = 1024;
   localparam int FFT_ADDR_W    = 10;

   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_state_t;

endpackage

// File: rtl/ifft_frame_feeder_if.sv
// Sample bus of the IFFT frame feeder: input handshake, output frame stream,
// status and FSM debug state.
//
// Input handshake: a sample on in_real/in_imag is transferred on a rising clk
// edge where in_valid && in_ready. in_ready does not depend on in_valid. If
// in_valid is high while in_ready is low, that sample is dropped and the
// feeder flags overflow, so a source must only raise in_valid when in_ready
// is high. The output side has no back-pressure: out_valid is high for whole
// frames only, with out_sop on sample 0 and out_eop on sample FRAME_LEN-1.
//
// Modports:
//   slave  : the feeder (receives in_*, drives everything else)
//   master : the environment around the feeder
interface ifft_frame_feeder_if #(
   parameter int DATA_W = ifft_pkg::FFT_DATA_W
);
   import ifft_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] in_real;
   logic [DATA_W-1:0] in_imag;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_real;
   logic [DATA_W-1:0] out_imag;
   logic              out_sop;
   logic              out_eop;
   logic              overflow;
   logic [15:0]       frame_cnt;
   rd_state_t         rd_state;

   modport slave (
      input  in_valid, in_real, in_imag,
      output in_ready, out_valid, out_real, out_imag, out_sop, out_eop,
             overflow, frame_cnt, rd_state
   );

   modport master (
      output in_valid, in_real, in_imag,
      input  in_ready, out_valid, out_real, out_imag, out_sop, out_eop,
             overflow, frame_cnt, rd_state
   );

endinterface

// File: rtl/ifft_feeder_bank_ram.sv
// Ping-pong frame store: simple dual-port RAM of two banks of FRAME_LEN words.
// Address is {bank, addr}. Synchronous write, registered read (1 cycle).
// Contents are not reset.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : {bank, addr} write address
//   wr_data : {real, imag} write word
//   rd_en   : read strobe; rd_data updates on the next edge
//   rd_addr : {bank, addr} read address
//   rd_data : registered read word
module ifft_feeder_bank_ram
   import ifft_pkg::*;
#(
   parameter int DATA_W = FFT_DATA_W,
   parameter int ADDR_W = FFT_ADDR_W
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [ADDR_W:0]     wr_addr,
   input  logic [2*DATA_W-1:0] wr_data,
   input  logic                rd_en,
   input  logic [ADDR_W:0]     rd_addr,
   output logic [2*DATA_W-1:0] rd_data
);

   logic [2*DATA_W-1:0] mem [2**(ADDR_W+1)];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/ifft_frame_feeder.sv
// Upstream stage of the IFFT wrapper. Collects samples that may arrive with
// gaps into a two-bank ping-pong buffer and replays each completed frame as a
// gapless burst of FRAME_LEN samples, so the downstream frame counter (which
// restarts whenever valid drops) always sees unbroken frames.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave view of ifft_frame_feeder_if (input handshake, output
//             stream, overflow, frame_cnt, read FSM state)
module ifft_frame_feeder
   import ifft_pkg::*;
#(
   parameter int DATA_W    = FFT_DATA_W,
   parameter int FRAME_LEN = FFT_FRAME_LEN,
   parameter int ADDR_W    = FFT_ADDR_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ifft_frame_feeder_if.slave   bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

   logic [1:0]          full;
   logic                wr_bank;
   logic [ADDR_W-1:0]   wr_addr;
   logic                rd_bank;
   logic [ADDR_W-1:0]   rd_addr;
   rd_state_t           rd_state;
   logic                accept;
   logic                wr_last;
   logic                rd_issue;
   logic                rd_last;
   logic [1:0]          full_set;
   logic [1:0]          full_clr;
   logic [2*DATA_W-1:0] rd_data;

   assign bus.in_ready = !full[wr_bank];
   assign accept       = bus.in_valid && bus.in_ready;
   assign wr_last      = accept && (wr_addr == LAST_ADDR);
   assign rd_issue     = (rd_state == RD_STREAM);
   assign rd_last      = rd_issue && (rd_addr == LAST_ADDR);

   // Writer sets and reader clears can never target the same bank in one
   // cycle (one needs the bank empty, the other full), so both one-hot
   // masks are applied together.
   assign full_set = {2{wr_last}} & {wr_bank, ~wr_bank};
   assign full_clr = {2{rd_last}} & {rd_bank, ~rd_bank};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full <= 2'b00;
      end else begin
         full <= (full & ~full_clr) | full_set;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_bank <= 1'b0;
         wr_addr <= '0;
      end else if (accept) begin
         if (wr_addr == LAST_ADDR) begin
            wr_addr <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_addr <= wr_addr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.overflow <= 1'b0;
      end else if (bus.in_valid && !bus.in_ready) begin
         bus.overflow <= 1'b1;
      end
   end

   // Read FSM. The strobes registered here line up with the RAM's registered
   // read data, giving one issue-to-output cycle for everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_state      <= RD_IDLE;
         rd_bank       <= 1'b0;
         rd_addr       <= '0;
         bus.out_valid <= 1'b0;
         bus.out_sop   <= 1'b0;
         bus.out_eop   <= 1'b0;
         bus.frame_cnt <= 16'd0;
      end else begin
         bus.out_valid <= rd_issue;
         bus.out_sop   <= rd_issue && (rd_addr == '0);
         bus.out_eop   <= rd_last;
         if (rd_last) begin
            bus.frame_cnt <= bus.frame_cnt + 16'd1;
         end
         case (rd_state)
            RD_IDLE: begin
               if (full[rd_bank]) begin
                  rd_state <= RD_STREAM;
                  rd_addr  <= '0;
               end
            end
            RD_STREAM: begin
               if (rd_addr == LAST_ADDR) begin
                  rd_addr <= '0;
                  rd_bank <= ~rd_bank;
                  // The other bank's full bit as registered now: a frame that
                  // completes this very edge is picked up one cycle later.
                  if (!full[~rd_bank]) begin
                     rd_state <= RD_IDLE;
                  end
               end else begin
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

   assign bus.rd_state = rd_state;
   assign bus.out_real = bus.out_valid ? rd_data[2*DATA_W-1:DATA_W] : '0;
   assign bus.out_imag = bus.out_valid ? rd_data[DATA_W-1:0]        : '0;

   ifft_feeder_bank_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr ({wr_bank, wr_addr}),
      .wr_data ({bus.in_real, bus.in_imag}),
      .rd_en   (rd_issue),
      .rd_addr ({rd_bank, rd_addr}),
      .rd_data (rd_data)
   );

endmodule
